// File: rtl/pixel_stream_gearbox_if.sv
// Stream bundles for the pixel gearbox: pixel input from the shading stage and
// the AXI-Stream beat output toward the VDMA.
interface pixel_if #(
    parameter int PIX_W = 24
) ();
    logic [PIX_W-1:0] pixel;
    logic             valid;
    logic             sof;
    logic             eol;
    logic             ready;

    modport master (output pixel, valid, sof, eol, input ready);
    modport slave  (input pixel, valid, sof, eol, output ready);
endinterface

interface axis_if #(
    parameter int TDATA_WIDTH = 32
) ();
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic                     tuser;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_stream_gearbox.sv
// Packs RGB pixels into AXI-Stream beats of TDATA_WIDTH bits, tags frame/line
// boundaries, tracks x/y position and flags malformed sof/eol markers.
module pixel_stream_gearbox #(
    parameter int COLOR_WIDTH   = 8,
    parameter int TDATA_WIDTH   = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        out_stream_aclk,
    input  logic        periph_reset,
    pixel_if.slave      pix,
    axis_if.master      out_stream,
    input  logic        err_clear,
    output logic        sof_err,
    output logic        eol_err,
    output logic [15:0] frame_count
);
    localparam int PIX_W  = 3 * COLOR_WIDTH;
    localparam int BUF_W  = TDATA_WIDTH + PIX_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int X_W    = $clog2(SCREEN_WIDTH + 1);
    localparam int Y_W    = $clog2(SCREEN_HEIGHT + 1);

    localparam logic [FILL_W-1:0] BEAT_BITS  = FILL_W'(TDATA_WIDTH);
    localparam logic [FILL_W-1:0] PIXEL_BITS = FILL_W'(PIX_W);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(SCREEN_HEIGHT - 1);

    logic [BUF_W-1:0]  pack_buf, buf_d, shifted, pix_ext;
    logic [FILL_W-1:0] fill, fill_d, base;
    logic              user_tag, user_tag_d, last_tag, last_tag_d;
    logic [X_W-1:0]    x_q, x_d, x_eff;
    logic [Y_W-1:0]    y_q, y_d, y_eff;
    logic              beat_valid, fire, accept;
    logic              line_end, sof_bad, eol_bad, frame_done;

    assign beat_valid = (fill >= BEAT_BITS);
    assign fire       = beat_valid && out_stream.tready;
    assign pix.ready  = !beat_valid || out_stream.tready;
    assign accept     = pix.valid && pix.ready;

    assign out_stream.tvalid = beat_valid;
    assign out_stream.tdata  = pack_buf[TDATA_WIDTH-1:0];
    assign out_stream.tkeep  = '1;
    assign out_stream.tuser  = beat_valid && user_tag;
    // tlast belongs to the beat that drains the buffer completely.
    assign out_stream.tlast  = beat_valid && last_tag && (fill == BEAT_BITS);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shifted    = fire ? (pack_buf >> TDATA_WIDTH) : pack_buf;
        base       = fire ? (fill - BEAT_BITS) : fill;
        pix_ext    = BUF_W'(pix.pixel);
        buf_d      = shifted;
        fill_d     = base;
        user_tag_d = user_tag && !fire;
        last_tag_d = last_tag && !(fire && (fill == BEAT_BITS));
        if (accept) begin
            if (pix.sof) begin
                // Resync: residual bits and their pending line marker are dropped.
                buf_d      = pix_ext;
                fill_d     = PIXEL_BITS;
                last_tag_d = 1'b0;
                user_tag_d = 1'b1;
            end else begin
                buf_d  = shifted | (pix_ext << base);
                fill_d = base + PIXEL_BITS;
            end
            if (pix.eol) begin
                last_tag_d = 1'b1;
            end
        end
    end

    always_comb begin
        x_eff      = pix.sof ? '0 : x_q;
        y_eff      = pix.sof ? '0 : y_q;
        line_end   = pix.eol || (x_eff == X_LAST);
        sof_bad    = pix.sof ? ((x_q != '0) || (y_q != '0)) : ((x_q == '0) && (y_q == '0));
        eol_bad    = pix.eol != (x_eff == X_LAST);
        frame_done = pix.eol && (y_eff == Y_LAST);
        x_d        = line_end ? '0 : x_eff + 1'b1;
        y_d        = y_eff;
        if (line_end) begin
            y_d = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            // NOTE: the packing buffer is cleared too, so tdata reads 0 and no
            // stale bits survive a mid-frame reset.
            pack_buf    <= '0;
            fill        <= '0;
            user_tag    <= 1'b0;
            last_tag    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_err     <= 1'b0;
            eol_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            pack_buf <= buf_d;
            fill     <= fill_d;
            user_tag <= user_tag_d;
            last_tag <= last_tag_d;
            if (accept) begin
                x_q <= x_d;
                y_q <= y_d;
            end
            if (accept && frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            // A fresh error in the same cycle as err_clear wins.
            sof_err <= (sof_err && !err_clear) || (accept && sof_bad);
            eol_err <= (eol_err && !err_clear) || (accept && eol_bad);
        end
    end
endmodule
